// File: rtl/matbi_watch_pkg.sv
// Shared types and time limits for the watch alarm blocks.
package matbi_watch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam int C_MAX_HOUR = 23;
  localparam int C_MAX_MIN  = 59;
  localparam int C_MAX_SEC  = 59;

endpackage

// File: rtl/matbi_sec_tick.sv
// Detects second transitions on a running seconds value; no tick until one
// cycle of history exists after reset.
module matbi_sec_tick #(
  parameter int P_SEC_BIT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P_SEC_BIT-1:0] i_sec,
  output logic                 o_sec_tick
);

  logic [P_SEC_BIT-1:0] r_prev_sec;
  logic                 r_prev_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_sec   <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_prev_sec   <= i_sec;
      r_prev_valid <= 1'b1;
    end
  end

  assign o_sec_tick = r_prev_valid && (i_sec != r_prev_sec);

endmodule

// File: rtl/matbi_watch_alarm.sv
// Alarm unit: rings when the watch time reaches the programmed alarm, with
// bounded snooze and auto-stop. All timing comes from second ticks.
module matbi_watch_alarm
  import matbi_watch_pkg::*;
#(
  parameter int P_SEC_BIT    = 6,
  parameter int P_MIN_BIT    = 6,
  parameter int P_HOUR_BIT   = 5,
  parameter int P_SNOOZE_MIN = 5,
  parameter int P_RING_SEC   = 60,
  parameter int P_MAX_SNOOZE = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [P_SEC_BIT-1:0]  i_sec,
  input  logic [P_MIN_BIT-1:0]  i_min,
  input  logic [P_HOUR_BIT-1:0] i_hour,
  input  logic                  i_arm,
  input  logic                  i_set_en,
  input  logic [P_HOUR_BIT-1:0] i_alarm_hour,
  input  logic [P_MIN_BIT-1:0]  i_alarm_min,
  input  logic                  i_snooze,
  input  logic                  i_stop,
  output logic                  o_ring,
  output logic                  o_armed,
  output logic [2:0]            o_snooze_cnt,
  output logic                  o_set_err,
  output logic [1:0]            o_dbg_state
);

  localparam int L_SNZ_W = $clog2(P_SNOOZE_MIN * 60 + 1);
  localparam logic [L_SNZ_W-1:0]    L_SNZ_LOAD = L_SNZ_W'(P_SNOOZE_MIN * 60);
  localparam logic [L_SNZ_W-1:0]    L_SNZ_ONE  = L_SNZ_W'(1);
  localparam logic [7:0]            L_RING_END = 8'(P_RING_SEC - 1);
  localparam logic [2:0]            L_MAX_SNZ  = 3'(P_MAX_SNOOZE);
  localparam logic [P_HOUR_BIT-1:0] L_MAX_HOUR = P_HOUR_BIT'(C_MAX_HOUR);
  localparam logic [P_MIN_BIT-1:0]  L_MAX_MIN  = P_MIN_BIT'(C_MAX_MIN);

  alarm_state_t          r_state;
  logic [P_HOUR_BIT-1:0] r_alm_hour;
  logic [P_MIN_BIT-1:0]  r_alm_min;
  logic [7:0]            r_ring_cnt;
  logic [L_SNZ_W-1:0]    r_snz_timer;
  logic [2:0]            r_snooze_cnt;
  logic                  r_set_err;

  logic w_tick;
  logic w_load_ok;
  logic w_match;

  matbi_sec_tick #(.P_SEC_BIT(P_SEC_BIT)) u_sec_tick (
    .clk        (clk),
    .reset      (reset),
    .i_sec      (i_sec),
    .o_sec_tick (w_tick)
  );

  assign w_load_ok = i_set_en && (i_alarm_hour <= L_MAX_HOUR) && (i_alarm_min <= L_MAX_MIN);
  assign w_match   = w_tick && (i_sec == '0) && (i_hour == r_alm_hour) && (i_min == r_alm_min);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_alm_hour   <= '0;
      r_alm_min    <= '0;
      r_ring_cnt   <= '0;
      r_snz_timer  <= '0;
      r_snooze_cnt <= '0;
      r_set_err    <= 1'b0;
    end else begin
      r_set_err <= i_set_en && !w_load_ok;
      if (w_load_ok) begin
        r_alm_hour <= i_alarm_hour;
        r_alm_min  <= i_alarm_min;
      end
      // Disarm beats everything; an accepted load beats in-state transitions.
      if (r_state != IDLE && !i_arm) begin
        r_state      <= IDLE;
        r_snooze_cnt <= '0;
      end else if (r_state != IDLE && w_load_ok) begin
        r_state      <= ARMED;
        r_snooze_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_snooze_cnt <= '0;
            if (i_arm) r_state <= ARMED;
          end
          ARMED: begin
            if (w_match) begin
              r_state    <= RINGING;
              r_ring_cnt <= '0;
            end
          end
          RINGING: begin
            if (i_stop) begin
              r_state      <= ARMED;
              r_snooze_cnt <= '0;
            end else if (i_snooze && r_snooze_cnt < L_MAX_SNZ) begin
              r_state      <= SNOOZE;
              r_snooze_cnt <= r_snooze_cnt + 3'd1;
              r_snz_timer  <= L_SNZ_LOAD;
            end else if (w_tick) begin
              if (r_ring_cnt == L_RING_END) begin
                r_state      <= ARMED;
                r_snooze_cnt <= '0;
              end else begin
                r_ring_cnt <= r_ring_cnt + 8'd1;
              end
            end
          end
          SNOOZE: begin
            if (i_stop) begin
              r_state      <= ARMED;
              r_snooze_cnt <= '0;
            end else if (w_tick) begin
              if (r_snz_timer == L_SNZ_ONE) begin
                r_state    <= RINGING;
                r_ring_cnt <= '0;
              end else begin
                r_snz_timer <= r_snz_timer - L_SNZ_ONE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_ring       = (r_state == RINGING);
  assign o_armed      = (r_state != IDLE);
  assign o_snooze_cnt = r_snooze_cnt;
  assign o_set_err    = r_set_err;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/matbi_watch_alarm.md
# matbi_watch_alarm

Alarm unit downstream of the watch counter: consumes the running `sec`/`min`/`hour` values and raises a ring output when the time matches a programmed alarm. Supports snooze with a bounded repeat count and an auto-stop timeout. All timing is derived from second transitions on the time inputs, so the block needs no frequency input and freezes when the watch is halted.

## Interface
- `P_SEC_BIT`, 6: width of `i_sec`.
- `P_MIN_BIT`, 6: width of `i_min` and `i_alarm_min`.
- `P_HOUR_BIT`, 5: width of `i_hour` and `i_alarm_hour`.
- `P_SNOOZE_MIN`, 5: snooze length in minutes (1..60).
- `P_RING_SEC`, 60: ring auto-stop time in seconds (1..255).
- `P_MAX_SNOOZE`, 3: maximum snoozes per alarm event (0..7).

Ports:
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `i_sec` input P_SEC_BIT: current second from watch (0..59).
- `i_min` input P_MIN_BIT: current minute (0..59).
- `i_hour` input P_HOUR_BIT: current hour (0..23).
- `i_arm` input 1: level; 1 = alarm enabled.
- `i_set_en` input 1: one-cycle strobe; load alarm time.
- `i_alarm_hour` input P_HOUR_BIT: alarm hour, sampled on `i_set_en`.
- `i_alarm_min` input P_MIN_BIT: alarm minute, sampled on `i_set_en`.
- `i_snooze` input 1: one-cycle pulse.
- `i_stop` input 1: one-cycle pulse.
- `o_ring` output 1: alarm sounding.
- `o_armed` output 1: state is not IDLE.
- `o_snooze_cnt` output 3: snoozes used in the current event.
- `o_set_err` output 1: one-cycle pulse; rejected load.

## Operation
- Second tick: `sec_tick = prev_valid && (i_sec != prev_sec)`. `prev_sec` is registered every cycle. `prev_valid` is set one cycle after reset.
- Alarm match: `sec_tick && i_sec == 0 && i_hour == alm_hour && i_min == alm_min`.
- Load: on `i_set_en`, if `i_alarm_hour <= 23` and `i_alarm_min <= 59`, write `alm_hour`/`alm_min`. Otherwise leave the registers unchanged and pulse `o_set_err` on the next cycle.
- An accepted load in RINGING or SNOOZE moves to ARMED and clears `o_snooze_cnt`.
- States (priority within a state, top to bottom):
  - IDLE:
    - `i_arm` = 1 → ARMED.
  - ARMED:
    - `i_arm` = 0 → IDLE.
    - match → RINGING; clear `ring_cnt`.
  - RINGING:
    - `i_arm` = 0 → IDLE.
    - `i_stop` → ARMED; clear snooze count.
    - `i_snooze` with `snooze_cnt < P_MAX_SNOOZE` → SNOOZE; increment snooze count; load `snz_timer = P_SNOOZE_MIN*60`.
    - `i_snooze` at the limit is ignored.
    - `sec_tick` with `ring_cnt == P_RING_SEC-1` → ARMED; clear snooze count. Otherwise `sec_tick` increments `ring_cnt`.
  - SNOOZE:
    - `i_arm` = 0 → IDLE.
    - `i_stop` → ARMED; clear snooze count.
    - `sec_tick` with `snz_timer == 1` → RINGING; clear `ring_cnt`. Otherwise `sec_tick` decrements the timer.
- Entering IDLE clears the snooze count. Load acceptance takes priority over the in-state transitions, but not over `i_arm` = 0.
- Width rules:
  - `snz_timer` is `$clog2(P_SNOOZE_MIN*60+1)` bits.
  - `ring_cnt` is 8 bits.
  - Counters never wrap; the comparisons above bound them.

## Timing
- Reset values:
  - Outputs: `o_ring` = 0, `o_armed` = 0, `o_snooze_cnt` = 0, `o_set_err` = 0.
  - Internal: state IDLE, `alm_hour` = 0, `alm_min` = 0, `prev_sec` = 0, `prev_valid` = 0.
- All outputs are decoded from registers: `o_ring` = (state == RINGING), `o_armed` = (state != IDLE).
- Match latency: `o_ring` rises on the first clock edge after `i_sec` becomes 0 at the alarm time. That is 1 cycle.
- `i_stop`/`i_snooze` sampled at edge N → state and `o_ring` change at edge N (visible after N).
- Watch stopped (time inputs static): no ticks, so ring and snooze timers freeze.
- Reset during RINGING/SNOOZE: the block returns to IDLE with alarm time cleared, even if `i_arm` stays high. It re-enters ARMED the cycle after reset deasserts.
- Simultaneous events:
  - Match in the same cycle as `i_arm` falling → IDLE, no ring.
  - `i_stop` together with `i_snooze` → stop wins.

## Structure
- Package `matbi_watch_pkg`:
  - `alarm_state_t` enum {IDLE, ARMED, RINGING, SNOOZE}.
  - Constants `C_MAX_HOUR` = 23, `C_MAX_MIN` = 59, `C_MAX_SEC` = 59.
- Sub-module `matbi_sec_tick`: `prev_sec` / `prev_valid` registers, outputs `sec_tick`. It is reusable by other watch consumers.
- Top: load/validate logic, FSM, `ring_cnt`, `snz_timer`, `snooze_cnt`.

## Test plan
- Alarm 07:30, armed, time driven to 07:29:59 → 07:30:00 → `o_ring` = 1 exactly 1 cycle after `i_sec` = 0. `o_ring` stays 0 at 07:30:00 if `i_arm` = 0.
- Ringing, no input for 60 sec ticks → `o_ring` falls after the 60th tick. State ARMED, `o_snooze_cnt` = 0.
- Ringing, `i_snooze` ×3, each followed by 300 ticks → re-ring each time, `o_snooze_cnt` = 1,2,3. A 4th `i_snooze` is ignored and `o_ring` stays 1.
- `i_set_en` with hour = 24, min = 10 → `o_set_err` pulses once and the alarm stays at 07:30. With hour = 23, min = 59 → accepted, no error.
- `i_stop` and `i_snooze` in the same cycle while ringing → ARMED, `o_ring` = 0, `o_snooze_cnt` = 0.
- `reset` pulsed mid-SNOOZE → all outputs 0, alarm 00:00. Watch halted with static time inputs → no ring.
